ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among N requesters. Priority is held in a one-hot rotating token, the same ring-counter structure the team already uses. After each grant ends, the token advances one position past the last owner. A mandatory one-cycle gap between grants guarantees break-before-make on the resource select lines.

---
 rtl/ring_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 45 ++++
 rtl/ring_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and constants for the ring round-robin arbiter and its picker.
package ring_arb_pkg;

  localparam int unsigned N_DEFAULT        = 4;
  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  function automatic int unsigned IDX_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority find: first set request at or above the
// one-hot pointer position, wrapping modulo N.
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_ptr,
  output logic                 o_valid,
  output logic [N-1:0]         o_gnt,
  output logic [IDX_W(N)-1:0]  o_idx
);

  localparam int unsigned IdxW = IDX_W(N);

  logic [IdxW-1:0] w_ptr_idx;
  logic [N-1:0]    w_rot;
  logic [IdxW:0]   w_sum;

  always_comb begin
    w_ptr_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_ptr[i]) w_ptr_idx = IdxW'(i);
    end
  end

  // Bit j of w_rot is req[(ptr + j) mod N]; the lowest set bit wins.
  always_comb begin
    w_rot   = N'({i_req, i_req} >> w_ptr_idx);
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_valid && w_rot[j]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, w_ptr_idx} + (IdxW + 1)'(j);
        if (w_sum >= (IdxW + 1)'(N)) w_sum = w_sum - (IdxW + 1)'(N);
        o_idx   = w_sum[IdxW-1:0];
      end
    end
    o_gnt = o_valid ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with one-hot rotating token and a one-cycle break-before-make gap.
// Optional grant-hold timeout with requester blocking when RING_ARB_TIMEOUT_EN is defined.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic                 o_busy,
  output logic [IDX_W(N)-1:0]  o_owner_id,
  output logic [N-1:0]         o_ptr,
  output logic                 o_timeout
);

  localparam int unsigned IdxW = IDX_W(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("ring_rr_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("ring_rr_arbiter: MAX_HOLD must be at least 1");
  end

  arb_state_e      r_state, w_state_d;
  logic [N-1:0]    r_gnt, w_gnt_d;
  logic            r_busy, w_busy_d;
  logic [IdxW-1:0] r_owner, w_owner_d;
  logic [N-1:0]    r_ptr, w_ptr_d;
  logic [N-1:0]    r_blocked, w_blocked_d;

  logic [N-1:0]    w_elig;
  logic            w_pick_valid;
  logic [N-1:0]    w_pick_gnt;
  logic [IdxW-1:0] w_pick_idx;
  logic            w_owner_req;
  logic [N-1:0]    w_next_ptr;
  logic            w_hold_limit;
  logic            w_force;

  assign w_elig      = i_req & ~r_blocked;
  assign w_owner_req = i_req[r_owner];
  // Token moves one past the owner: rotate the one-hot grant left.
  assign w_next_ptr  = {r_gnt[N-2:0], r_gnt[N-1]};
  assign w_force     = (r_state == GRANT) && w_owner_req && w_hold_limit;

  rr_pick #(
    .N (N)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx)
  );

`ifdef RING_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] r_hold;
  logic             r_timeout;

  assign w_hold_limit = (r_hold == HoldW'(MAX_HOLD - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == IDLE && w_pick_valid) begin
        r_hold <= '0;
      end else if (r_state == GRANT) begin
        r_hold <= r_hold + HoldW'(1);
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_hold_limit = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_busy_d  = r_busy;
    w_owner_d = r_owner;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_d   = w_pick_gnt;
          w_owner_d = w_pick_idx;
          w_busy_d  = 1'b1;
          w_state_d = GRANT;
        end else begin
          w_gnt_d  = '0;
          w_busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (!w_owner_req || w_force) begin
          w_gnt_d   = '0;
          w_busy_d  = 1'b0;
          w_ptr_d   = w_next_ptr;
          w_state_d = GAP;
        end
      end
      GAP: begin
        w_state_d = IDLE;
      end
      default: begin
        w_gnt_d   = '0;
        w_busy_d  = 1'b0;
        w_state_d = IDLE;
      end
    endcase
    // A block lifts as soon as its requester is seen low.
    w_blocked_d = (r_blocked & i_req) | (w_force ? r_gnt : '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_ptr     <= N'(1);
      r_blocked <= '0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_busy    <= w_busy_d;
      r_owner   <= w_owner_d;
      r_ptr     <= w_ptr_d;
      r_blocked <= w_blocked_d;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_busy     = r_busy;
  assign o_owner_id = r_owner;
  assign o_ptr      = r_ptr;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios plus random
// request traffic compared against a behavioural model of the arbitration rules.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef RING_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         busy;
  logic [1:0]   owner_id;
  logic [N-1:0] ptr;
  logic         timeout;

  always #5 clk = ~clk;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .o_gnt      (gnt),
    .o_busy     (busy),
    .o_owner_id (owner_id),
    .o_ptr      (ptr),
    .o_timeout  (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: mode 0 = arbitrating, 1 = resource held, 2 = break-before-make gap.
  int           m_mode;
  int           m_owner;
  int           m_ptr;
  int           m_hold;
  bit           m_granted;
  bit           m_timeout;
  bit [N-1:0]   m_blk;

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    m_granted = 0; m_timeout = 0; m_blk = '0;
  endtask

  task automatic model_step(input bit [N-1:0] r);
    bit [N-1:0] elig;
    bit [N-1:0] set_blk;
    int         w;
    elig      = r & ~m_blk;
    set_blk   = '0;
    w         = -1;
    m_timeout = 0;
    case (m_mode)
      0: begin
        for (int i = 0; i < N; i++) begin
          if (w < 0 && elig[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        end
        if (w >= 0) begin
          m_owner = w; m_granted = 1; m_mode = 1; m_hold = 0;
        end else begin
          m_granted = 0;
        end
      end
      1: begin
        if (!r[m_owner]) begin
          m_granted = 0; m_ptr = (m_owner + 1) % N; m_mode = 2;
        end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
          m_granted = 0; m_ptr = (m_owner + 1) % N; m_mode = 2;
          m_timeout = 1; set_blk[m_owner] = 1'b1;
        end else begin
          m_hold++;
        end
      end
      default: m_mode = 0;
    endcase
    m_blk = (m_blk & r) | set_blk;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".gnt"},     32'(gnt),      m_granted ? (1 << m_owner) : 0);
    check({tag, ".busy"},    32'(busy),     32'(m_granted));
    check({tag, ".owner"},   32'(owner_id), m_owner);
    check({tag, ".ptr"},     32'(ptr),      1 << m_ptr);
    check({tag, ".timeout"}, 32'(timeout),  32'(m_timeout));
  endtask

  task automatic cycle(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r);
    @(negedge clk);
    compare_all(tag);
  endtask

  logic [N-1:0] rnd_req;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Single requester
    cycle(4'b0010, "single");
    check("single.gnt_now", 32'(gnt), 32'h2);
    check("single.owner_now", 32'(owner_id), 32'h1);
    repeat (4) cycle(4'b0010, "single.hold");
    cycle(4'b0000, "single.rel");
    check("single.rel_gnt", 32'(gnt), 32'h0);
    check("single.rel_ptr", 32'(ptr), 32'h4);
    cycle(4'b0000, "single.gap");

    // Asynchronous reset mid-grant
    cycle(4'b0100, "rst.grant");
    check("rst.pre_gnt", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.async_gnt", 32'(gnt), 32'h0);
    check("rst.async_busy", 32'(busy), 32'h0);
    check("rst.async_ptr", 32'(ptr), 32'h1);
    repeat (2) cycle(4'b0100, "rst.hold");
    rst_n = 1'b1;

    // All requesting: order 0,1,2,3,0 with gap + idle between grants
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, "rr.grant");
      check("rr.order", 32'(gnt), 1 << (k % 4));
      cycle(4'b1111, "rr.hold");
      cycle(4'b1111 & ~(4'b0001 << (k % 4)), "rr.rel");
      check("rr.rel_gnt", 32'(gnt), 32'h0);
      cycle(4'b1111, "rr.gap");
      check("rr.gap_gnt", 32'(gnt), 32'h0);
    end

    // Wrap and priority from ptr=1000
    cycle(4'b0000, "wrap.rel");
    cycle(4'b0000, "wrap.gap");
    cycle(4'b0100, "wrap.g2");
    cycle(4'b0000, "wrap.r2");
    check("wrap.ptr3", 32'(ptr), 32'h8);
    cycle(4'b0000, "wrap.gap2");
    cycle(4'b0101, "wrap.g0");
    check("wrap.gnt0", 32'(gnt), 32'h1);
    cycle(4'b0000, "wrap.r0");
    check("wrap.ptr1", 32'(ptr), 32'h2);
    cycle(4'b0101, "wrap.gap3");
    cycle(4'b0101, "wrap.g2b");
    check("wrap.gnt2", 32'(gnt), 32'h4);
    cycle(4'b0000, "wrap.r2b");
    cycle(4'b0000, "wrap.gap4");

`ifdef RING_ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles, then block until req[0] drops
    cycle(4'b0001, "to.grant");
    repeat (3) begin
      cycle(4'b0001, "to.hold");
      check("to.hold_gnt", 32'(gnt), 32'h1);
    end
    cycle(4'b0001, "to.force");
    check("to.pulse", 32'(timeout), 32'h1);
    check("to.gnt_off", 32'(gnt), 32'h0);
    cycle(4'b0001, "to.gap");
    check("to.pulse_end", 32'(timeout), 32'h0);
    cycle(4'b0001, "to.blocked");
    check("to.no_regrant", 32'(gnt), 32'h0);
    cycle(4'b0011, "to.other");
    check("to.other_gnt", 32'(gnt), 32'h2);
    cycle(4'b0000, "to.rel");
    cycle(4'b0000, "to.gap2");

    // Release in the same cycle the limit is reached
    cycle(4'b0001, "col.grant");
    repeat (3) cycle(4'b0001, "col.hold");
    cycle(4'b0000, "col.rel");
    check("col.no_timeout", 32'(timeout), 32'h0);
    cycle(4'b0001, "col.gap");
    cycle(4'b0001, "col.regrant");
    check("col.regrant_gnt", 32'(gnt), 32'h1);
    cycle(4'b0000, "col.rel2");
    cycle(4'b0000, "col.gap2");
`endif

    // Random traffic: each request bit toggles with probability 1/4 per cycle
    rnd_req = '0;
    for (int i = 0; i < 800; i++) begin
      rnd_req = rnd_req ^ N'($urandom & $urandom);
      cycle(rnd_req, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
